neuron_mac_sequencer: RTL and testbench
=======================================

// Module: neuron_mac_sequencer
// PURPOSE
//  Sequences one neuron's multiply-accumulate over NUM_WEIGHTS streamed inputs.
//  Accepts inputs via valid/ready and issues weight-memory reads in lock-step.
//  Multiplies, accumulates, then rescales and saturates the sum to DATA_BITS.
//  Presents the result on a valid/ready output to the activation stage.
//  Sits between the layer input stream and the per-neuron weight memory.
// PARAMETERS
//  DATA_BITS    16   signed fixed-point width of inputs, weights and result
//  NUM_WEIGHTS  784  inputs/weights per neuron (>=2)
//  FRAC_BITS    8    fractional bits of the data format
//  ADDR_BITS    $clog2(NUM_WEIGHTS)  localparam, weight address width
//  ACC_BITS     2*DATA_BITS+ADDR_BITS  localparam, accumulator width (no overflow)
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-high
//  in_data    in   DATA_BITS  signed neuron input sample
//  in_valid   in   1          in_data valid
//  in_ready   out  1          block can accept a sample this cycle
//  w_rd_en    out  1          weight memory read strobe
//  w_addr     out  ADDR_BITS  weight address, valid with w_rd_en
//  w_data     in   DATA_BITS  signed weight, valid exactly 1 cycle after w_rd_en
//  out_data   out  DATA_BITS  saturated neuron sum
//  out_valid  out  1          out_data valid, held until accepted
//  out_ready  in   1          downstream accepts out_data
//  busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, count=0, acc=0, pipe valids=0; in_ready=1, w_rd_en=0,
//   w_addr=0, out_data=0, out_valid=0, busy=0. Reset mid-operation discards all.
//  Accept = in_valid & in_ready. On accept: w_rd_en=1, w_addr=count (comb.),
//   in_data registered to stage1, count++. No accept -> w_rd_en=0 (bubble).
//  Stage1 (t+1): product = signed(x_reg) * signed(w_data), 2*DATA_BITS, registered.
//  Stage2 (t+2): acc += sign-extended product. Per-stage valid bits carry bubbles.
//  FSM:
//   IDLE:   in_ready=1; accept -> ACCUM (acc already 0).
//   ACCUM:  in_ready=1; accept with count==NUM_WEIGHTS-1 -> DRAIN, count wraps to 0.
//           in_valid low -> stay, no read issued.
//   DRAIN:  in_ready=0; wait until both pipe valids clear (exactly 2 cycles),
//           then register out_data=sat(acc>>>FRAC_BITS), out_valid=1 -> OUTPUT.
//   OUTPUT: in_ready=0; out_valid held, out_data stable;
//           out_valid&out_ready -> out_valid=0, acc=0, -> IDLE.
//  Latency: last accept to out_valid rising = 3 cycles.
//  Sat: arithmetic shift; clamp to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
//  No overlap: next vector cannot start until result handed off (in_ready=0).
//  w_addr never exceeds NUM_WEIGHTS-1; count wraps to 0 after the last weight.
// STRUCTURE
//  nn_pkg: typedef enum {IDLE,ACCUM,DRAIN,OUTPUT} mac_state_t;
//   function sat_shift(acc, FRAC_BITS, DATA_BITS).
//  Sub-module neuron_mac_pipe: stage1/stage2 regs, valid bits, acc, acc clear.
//  Top holds FSM, count, handshakes, output register.
// TESTING (NUM_WEIGHTS=4, DATA_BITS=16, FRAC_BITS=8)
//  1) in 4x0x0100, w 4x0x0100 back-to-back -> w_addr 0,1,2,3; out_data=0x0400
//     3 cycles after 4th accept.
//  2) in 4x0x7FFF, w 4x0x7FFF -> out_data=0x7FFF (positive saturation).
//  3) in 4x0xFF00 (-1.0), w 4x0x0100 -> out_data=0xFC00.
//     In 4x0x8000, w 4x0x7FFF -> out_data=0x8000 (negative saturation).
//  4) in_valid toggled 1,0,0,1,1,0,1 over vector from 1) -> identical 0x0400;
//     w_rd_en only on accepts.
//  5) out_ready low 5 cycles after out_valid -> out_valid/out_data stable,
//     in_ready=0, in_valid ignored; IDLE the cycle after out_ready=1.
//  6) reset after 2 accepts -> all outputs at reset values; next vector of
//     test 1 -> out_data=0x0400 (no residue).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC sequencer.
// The saturating rescale works on a wide signed value so every accumulator width fits.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } mac_state_t;

  localparam int SAT_W = 64;

  // Arithmetic right shift by frac_bits, then clamp to the signed data_bits range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_bits,
    input int                      data_bits
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_bits - 1));
    if (sh > hi) begin
      return hi;
    end else if (sh < lo) begin
      return lo;
    end else begin
      return sh;
    end
  endfunction

endpackage

// File: rtl/neuron_mac_pipe.sv
// Two-stage multiply/accumulate datapath with per-stage valid bits.
// Stage1 multiplies the held sample by the weight returned one cycle after the read.
module neuron_mac_pipe
  import nn_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10,
  localparam int ACC_BITS = 2*DATA_BITS + ADDR_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        accept,
  input  logic signed [DATA_BITS-1:0] in_data,
  input  logic signed [DATA_BITS-1:0] w_data,
  input  logic                        acc_clr,
  output logic                        v1,
  output logic                        v2,
  output logic signed [ACC_BITS-1:0]  acc
);

  logic signed [DATA_BITS-1:0]   x_r;
  logic                          v1_r;
  logic signed [2*DATA_BITS-1:0] prod_r;
  logic                          v2_r;
  logic signed [ACC_BITS-1:0]    acc_r;

  // Stage0 capture: hold the accepted sample until its weight arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r  <= '0;
      v1_r <= 1'b0;
    end else begin
      v1_r <= accept;
      if (accept) begin
        x_r <= in_data;
      end
    end
  end

  // Stage1 multiply: bubbles pass through as a cleared valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_r <= '0;
      v2_r   <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        prod_r <= x_r * w_data;
      end
    end
  end

  // Stage2 accumulate; clear wins so a handed-off result never leaks into the next vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
    end else if (acc_clr) begin
      acc_r <= '0;
    end else if (v2_r) begin
      acc_r <= acc_r + ACC_BITS'(prod_r);
    end
  end

  assign v1  = v1_r;
  assign v2  = v2_r;
  assign acc = acc_r;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one neuron's MAC over NUM_WEIGHTS streamed samples with lock-step weight reads,
// then presents the rescaled, saturated sum on a valid/ready output.
module neuron_mac_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int NUM_WEIGHTS = 784,
  parameter int FRAC_BITS   = 8,
  localparam int ADDR_BITS  = $clog2(NUM_WEIGHTS),
  localparam int ACC_BITS   = 2*DATA_BITS + ADDR_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_BITS-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        w_rd_en,
  output logic [ADDR_BITS-1:0]        w_addr,
  input  logic signed [DATA_BITS-1:0] w_data,
  output logic signed [DATA_BITS-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_WEIGHTS - 1);

  mac_state_t                  state_r;
  mac_state_t                  state_nxt_s;
  logic [ADDR_BITS-1:0]        count_r;
  logic [ADDR_BITS-1:0]        count_nxt_s;
  logic                        in_ready_r;
  logic                        busy_r;
  logic signed [DATA_BITS-1:0] out_data_r;
  logic                        out_valid_r;
  logic                        accept_s;
  logic                        load_out_s;
  logic                        hand_off_s;
  logic                        v1_s;
  logic                        v2_s;
  logic signed [ACC_BITS-1:0]  acc_s;

  assign accept_s = in_valid & in_ready_r;

  neuron_mac_pipe #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .accept  (accept_s),
    .in_data (in_data),
    .w_data  (w_data),
    .acc_clr (hand_off_s),
    .v1      (v1_s),
    .v2      (v2_s),
    .acc     (acc_s)
  );

  // Next-state, sample counter and output load/hand-off decisions.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    load_out_s  = 1'b0;
    hand_off_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          count_nxt_s = count_r + ADDR_BITS'(1);
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && (count_r == LAST_IDX)) begin
          count_nxt_s = '0;
          state_nxt_s = DRAIN;
        end else if (accept_s) begin
          count_nxt_s = count_r + ADDR_BITS'(1);
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DRAIN: begin
        // The last product lands in acc two cycles after the final accept.
        if (!v1_s && !v2_s) begin
          load_out_s  = 1'b1;
          state_nxt_s = OUTPUT;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      OUTPUT: begin
        if (out_valid_r && out_ready) begin
          hand_off_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUTPUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = '0;
      end
    endcase
  end

  // State, counter and the status flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= '0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == ACCUM);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  // Result register: loaded once per vector, held until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (load_out_s) begin
      out_data_r  <= DATA_BITS'(sat_shift(SAT_W'(acc_s), FRAC_BITS, DATA_BITS));
      out_valid_r <= 1'b1;
    end else if (hand_off_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign w_rd_en   = accept_s;
  assign w_addr    = count_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a 4-weight neuron and a
// one-cycle-latency weight memory model.
module tb_neuron_mac_sequencer;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        w_rd_en;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [15:0] wmem [NW];
  logic [1:0]  addr_log [$];
  int          rd_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  neuron_mac_sequencer #(
    .DATA_BITS   (16),
    .NUM_WEIGHTS (NW),
    .FRAC_BITS   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Weight memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_data <= wmem[w_addr];
      rd_cnt++;
      addr_log.push_back(w_addr);
    end else begin
      w_data <= 16'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_w_rd_en"}, 32'(w_rd_en), 32'd0);
    check_eq({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called on a negedge with the DUT idle. pat gives in_valid per cycle (LSB first),
  // hold is the number of cycles out_ready stays low once out_valid is up.
  task automatic run_vec(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                         input logic [6:0] pat, input int plen, input int hold,
                         input logic [15:0] exp);
    int   acc_n;
    int   i;
    int   lat;
    int   rd0;
    logic v;
    acc_n = 0;
    i     = 0;
    for (int k = 0; k < NW; k++) wmem[k] = wv;
    rd0 = rd_cnt;
    while (acc_n < NW) begin
      v        = (i < plen) ? pat[i] : 1'b1;
      in_valid = v;
      in_data  = v ? xv : 16'($urandom);
      #1;
      check_eq($sformatf("%s_rd_en_c%0d", tag, i), 32'(w_rd_en), 32'(v));
      @(negedge clk);
      if (v) acc_n++;
      i++;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    check_eq({tag, "_out_data"}, 32'(out_data), 32'(exp));
    check_eq({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(NW));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      #1;
      check_eq($sformatf("%s_hold%0d_valid", tag, h), 32'(out_valid), 32'd1);
      check_eq($sformatf("%s_hold%0d_data", tag, h), 32'(out_data), 32'(exp));
      check_eq($sformatf("%s_hold%0d_in_ready", tag, h), 32'(in_ready), 32'd0);
      check_eq($sformatf("%s_hold%0d_rd_en", tag, h), 32'(w_rd_en), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(negedge clk);

    addr_log.delete();
    run_vec("t1", 16'h0100, 16'h0100, 7'b1111111, 7, 0, 16'h0400);
    check_eq("t1_addr_count", 32'(addr_log.size()), 32'd4);
    for (int a = 0; a < NW; a++) begin
      if (a < addr_log.size())
        check_eq($sformatf("t1_addr%0d", a), 32'(addr_log[a]), 32'(a));
    end

    run_vec("t2_possat", 16'h7FFF, 16'h7FFF, 7'b1111111, 7, 0, 16'h7FFF);
    run_vec("t3_neg", 16'hFF00, 16'h0100, 7'b1111111, 7, 0, 16'hFC00);
    run_vec("t3_negsat", 16'h8000, 16'h7FFF, 7'b1111111, 7, 0, 16'h8000);
    run_vec("t4_bubbles", 16'h0100, 16'h0100, 7'b1011001, 7, 0, 16'h0400);
    run_vec("t5_backpr", 16'h0100, 16'h0100, 7'b1111111, 7, 5, 16'h0400);

    // Two samples accepted, then reset in the middle of the vector.
    for (int k = 0; k < NW; k++) wmem[k] = 16'h0100;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset("t6_mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec("t6_after", 16'h0100, 16'h0100, 7'b1111111, 7, 0, 16'h0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
